// File: rtl/uart_tx_sched_pkg.sv
// Shared types and constants for the UART TX scheduler.
package uart_tx_sched_pkg;

  localparam int NUM_REQ = 2;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_ACK,
    WAIT_DONE,
    GAP
  } sched_state_t;

endpackage

// File: rtl/uart_tx_rr_arb.sv
// Two-way round-robin write arbiter in front of the shared TX FIFO.
// One grant at most per cycle; nothing is granted while the FIFO is full
// or during a synchronous clear.
module uart_tx_rr_arb
  import uart_tx_sched_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               sync_reset,
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic [WIDTH-1:0]   i_data0,
  input  logic [WIDTH-1:0]   i_data1,
  input  logic               i_full,
  output logic [NUM_REQ-1:0] o_grant,
  output logic               o_accept,
  output logic [WIDTH-1:0]   o_data
);

  logic               r_rr_last;
  logic [NUM_REQ-1:0] w_grant;

  // Grant selection: a lone requester wins, contention goes to the one not served last.
  always_comb begin
    w_grant = '0;
    if (reset_n && !sync_reset && !i_full) begin
      if (&i_valid) begin
        w_grant = r_rr_last ? 2'b01 : 2'b10;
      end else begin
        w_grant = i_valid;
      end
    end
  end

  // Remember the last granted index; reset value 1 makes requester 0 win first.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rr_last <= 1'b1;
    end else if (sync_reset) begin
      r_rr_last <= 1'b1;
    end else if (|w_grant) begin
      r_rr_last <= w_grant[1];
    end
  end

  assign o_grant  = w_grant;
  assign o_accept = |w_grant;
  assign o_data   = w_grant[1] ? i_data1 : i_data0;

endmodule

// File: rtl/uart_tx_scheduler.sv
// UART TX scheduler: arbitrates two byte producers onto one TX FIFO and
// drains the FIFO one byte at a time into the UART transmitter core.
// Optional per-requester push counters: define UART_TX_SCHED_STATS_EN.
module uart_tx_scheduler
  import uart_tx_sched_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int GAP_CYCLES  = 0,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sync_reset,
  input  logic             enable,
`ifdef UART_TX_SCHED_STATS_EN
  input  logic             stats_clear,
  output logic [15:0]      tx_count0,
  output logic [15:0]      tx_count1,
`endif
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             fifo_write,
  output logic [WIDTH-1:0] fifo_data_in,
  output logic             fifo_read,
  input  logic [WIDTH-1:0] fifo_top_data_out,
  input  logic             fifo_not_empty,
  input  logic             fifo_full,
  output logic             tx_start,
  output logic [WIDTH-1:0] tx_data,
  input  logic             tx_active,
  output logic             tx_err
);

  // A zero-valued parameter would give a zero-width counter; keep at least one bit.
  localparam int TO_W  = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  logic [NUM_REQ-1:0] w_grant;
  logic               w_accept;

  uart_tx_rr_arb #(
    .WIDTH(WIDTH)
  ) u_arb (
    .clk       (clk),
    .reset_n   (reset_n),
    .sync_reset(sync_reset),
    .i_valid   ({req1_valid, req0_valid}),
    .i_data0   (req0_data),
    .i_data1   (req1_data),
    .i_full    (fifo_full),
    .o_grant   (w_grant),
    .o_accept  (w_accept),
    .o_data    (fifo_data_in)
  );

  assign req0_ready = w_grant[0];
  assign req1_ready = w_grant[1];
  assign fifo_write = w_accept;

  sched_state_t     r_state, w_next;
  logic [WIDTH-1:0] r_tx_data, w_tx_data_nx;
  logic             r_tx_err, w_tx_err_nx;
  logic [TO_W-1:0]  r_to_cnt, w_to_nx, w_to_inc;
  logic [GAP_W-1:0] r_gap_cnt, w_gap_nx;
  logic             w_fifo_read, w_tx_start;

  // Drain sequencing: next state, strobes and next register values.
  always_comb begin
    w_next       = r_state;
    w_fifo_read  = 1'b0;
    w_tx_start   = 1'b0;
    w_tx_data_nx = r_tx_data;
    w_tx_err_nx  = r_tx_err;
    w_to_nx      = r_to_cnt;
    w_gap_nx     = r_gap_cnt;
    w_to_inc     = r_to_cnt + 1'b1;
    case (r_state)
      IDLE: begin
        if (enable && fifo_not_empty) begin
          w_fifo_read  = 1'b1;
          w_tx_data_nx = fifo_top_data_out;
          w_next       = ISSUE;
        end
      end
      ISSUE: begin
        w_tx_start = 1'b1;
        w_to_nx    = '0;
        w_next     = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (tx_active) begin
          w_next = WAIT_DONE;
        end else begin
          w_to_nx = w_to_inc;
          // Abandon the byte on the edge where the count reaches its limit.
          if (w_to_inc == TO_W'(ACK_TIMEOUT - 1)) begin
            w_tx_err_nx = 1'b1;
            w_next      = IDLE;
          end
        end
      end
      WAIT_DONE: begin
        if (!tx_active) begin
          w_gap_nx = '0;
          w_next   = (GAP_CYCLES == 0) ? IDLE : GAP;
        end
      end
      GAP: begin
        if (r_gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
          w_gap_nx = '0;
          w_next   = IDLE;
        end else begin
          w_gap_nx = r_gap_cnt + 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
    // Synchronous clear overrides everything, including an in-flight byte.
    if (sync_reset) begin
      w_next       = IDLE;
      w_fifo_read  = 1'b0;
      w_tx_start   = 1'b0;
      w_tx_data_nx = '0;
      w_tx_err_nx  = 1'b0;
      w_to_nx      = '0;
      w_gap_nx     = '0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_tx_data <= '0;
      r_tx_err  <= 1'b0;
      r_to_cnt  <= '0;
      r_gap_cnt <= '0;
    end else begin
      r_state   <= w_next;
      r_tx_data <= w_tx_data_nx;
      r_tx_err  <= w_tx_err_nx;
      r_to_cnt  <= w_to_nx;
      r_gap_cnt <= w_gap_nx;
    end
  end

  assign fifo_read = w_fifo_read;
  assign tx_start  = w_tx_start;
  assign tx_data   = r_tx_data;
  assign tx_err    = r_tx_err;

`ifdef UART_TX_SCHED_STATS_EN
  logic [15:0] r_cnt0, r_cnt1;

  // Per-requester accepted-push counters; clear wins over a same-cycle push.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else if (sync_reset || stats_clear) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (w_grant[0]) r_cnt0 <= r_cnt0 + 16'd1;
      if (w_grant[1]) r_cnt1 <= r_cnt1 + 16'd1;
    end
  end

  assign tx_count0 = r_cnt0;
  assign tx_count1 = r_cnt1;
`endif

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with a 4-entry (3 usable) FIFO model
// and a UART TX core model (busy 2 cycles after tx_start, for 10 cycles).
module tb_uart_tx_scheduler;
  import uart_tx_sched_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n, sync_reset, enable;
  logic       req0_valid, req1_valid, req0_ready, req1_ready;
  logic [7:0] req0_data, req1_data;
  logic       fifo_write, fifo_read, fifo_not_empty, fifo_full;
  logic [7:0] fifo_data_in, fifo_top_data_out;
  logic       tx_start, tx_active, tx_err;
  logic [7:0] tx_data;
`ifdef UART_TX_SCHED_STATS_EN
  logic        stats_clear = 1'b0;
  logic [15:0] tx_count0, tx_count1;
`endif

  always #5 clk = ~clk;

  uart_tx_scheduler #(
    .WIDTH      (8),
    .GAP_CYCLES (5),
    .ACK_TIMEOUT(64)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .sync_reset       (sync_reset),
    .enable           (enable),
`ifdef UART_TX_SCHED_STATS_EN
    .stats_clear      (stats_clear),
    .tx_count0        (tx_count0),
    .tx_count1        (tx_count1),
`endif
    .req0_valid       (req0_valid),
    .req0_data        (req0_data),
    .req0_ready       (req0_ready),
    .req1_valid       (req1_valid),
    .req1_data        (req1_data),
    .req1_ready       (req1_ready),
    .fifo_write       (fifo_write),
    .fifo_data_in     (fifo_data_in),
    .fifo_read        (fifo_read),
    .fifo_top_data_out(fifo_top_data_out),
    .fifo_not_empty   (fifo_not_empty),
    .fifo_full        (fifo_full),
    .tx_start         (tx_start),
    .tx_data          (tx_data),
    .tx_active        (tx_active),
    .tx_err           (tx_err)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // FIFO model: 4 slots, full at 3 entries.
  logic [7:0] fmem [4];
  logic [2:0] fcnt;
  logic [1:0] frd, fwr;
  assign fifo_not_empty    = (fcnt != 3'd0);
  assign fifo_full         = (fcnt == 3'd3);
  assign fifo_top_data_out = fmem[frd];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n || sync_reset) begin
      fcnt <= 3'd0;
      frd  <= 2'd0;
      fwr  <= 2'd0;
    end else begin
      if (fifo_write) begin
        fmem[fwr] <= fifo_data_in;
        fwr       <= fwr + 2'd1;
      end
      if (fifo_read) frd <= frd + 2'd1;
      fcnt <= fcnt + {2'b00, fifo_write} - {2'b00, fifo_read};
    end
  end

  // TX core model.
  logic tx_mute;
  logic m_dly;
  int   m_len;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_active <= 1'b0;
      m_dly     <= 1'b0;
      m_len     <= 0;
    end else if (tx_start && !tx_mute) begin
      m_dly <= 1'b1;
    end else if (m_dly) begin
      m_dly     <= 1'b0;
      tx_active <= 1'b1;
      m_len     <= 9;
    end else if (tx_active) begin
      if (m_len == 0) tx_active <= 1'b0;
      else m_len <= m_len - 1;
    end
  end

  // Event logs, sampled on the clock edge before any register update.
  int         both_rdy = 0;
  int         read_empty = 0;
  int         read_cyc_q[$];
  int         start_cyc_q[$];
  logic [7:0] start_data_q[$];
  int         fall_cyc_q[$];
  logic       prev_act = 1'b0;

  always @(posedge clk) begin
    if (reset_n) begin
      if (fifo_read) begin
        read_cyc_q.push_back(cyc);
        if (!fifo_not_empty) read_empty++;
      end
      if (tx_start) begin
        start_cyc_q.push_back(cyc);
        start_data_q.push_back(tx_data);
      end
      if (req0_ready && req1_ready) both_rdy++;
      if (prev_act && !tx_active) fall_cyc_q.push_back(cyc);
    end
    prev_act = tx_active;
    cyc++;
  end

  task automatic clear_logs();
    read_cyc_q.delete();
    start_cyc_q.delete();
    start_data_q.delete();
    fall_cyc_q.delete();
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; sync_reset = 1'b0; enable = 1'b0; tx_mute = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; req0_data = 8'h00; req1_data = 8'h00;
    #12;
    n_tests++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL reset_tx_start got %0b exp 0", tx_start); end
    n_tests++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data got %h exp 00", tx_data); end
    n_tests++; if (tx_err !== 1'b0) begin n_fail++; $display("FAIL reset_tx_err got %0b exp 0", tx_err); end
    n_tests++; if (fifo_write !== 1'b0 || fifo_read !== 1'b0) begin n_fail++; $display("FAIL reset_fifo_strobes got w=%0b r=%0b exp 0/0", fifo_write, fifo_read); end
    n_tests++; if (dut.r_state !== IDLE) begin n_fail++; $display("FAIL reset_state got %s exp IDLE", dut.r_state.name()); end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    int n;
    clear_logs();
    enable = 1'b1; req0_valid = 1'b1; req0_data = 8'h5A;
    #1;
    n = cyc;
    n_tests++; if (req0_ready !== 1'b1 || fifo_write !== 1'b1) begin n_fail++; $display("FAIL single_accept got rdy=%0b wr=%0b exp 1/1", req0_ready, fifo_write); end
    n_tests++; if (fifo_data_in !== 8'h5A) begin n_fail++; $display("FAIL single_push_data got %h exp 5a", fifo_data_in); end
    @(negedge clk);
    req0_valid = 1'b0;
    wait_until(n + 24);
    n_tests++; if (read_cyc_q.size() != 1 || read_cyc_q[0] != n + 1) begin n_fail++; $display("FAIL single_read got %0d reads exp 1 at cycle %0d", read_cyc_q.size(), n + 1); end
    n_tests++; if (start_cyc_q.size() != 1 || start_cyc_q[0] != n + 2) begin n_fail++; $display("FAIL single_start_latency got %0d starts exp 1 at cycle %0d", start_cyc_q.size(), n + 2); end
    n_tests++; if (start_data_q.size() != 1 || start_data_q[0] !== 8'h5A) begin n_fail++; $display("FAIL single_tx_data got %0d entries exp one 5a", start_data_q.size()); end
    n_tests++; if (dut.r_state !== IDLE) begin n_fail++; $display("FAIL single_back_to_idle got %s exp IDLE", dut.r_state.name()); end
  endtask

  int rr_base;

  task automatic test_round_robin();
    logic [7:0] d0, d1;
    logic       exp0;
    sync_reset = 1'b1;
    @(negedge clk);
    sync_reset = 1'b0;
    clear_logs();
    rr_base = cyc;
    d0 = 8'h10; d1 = 8'h20;
    for (int i = 0; i < 4; i++) begin
      req0_valid = 1'b1; req1_valid = 1'b1; req0_data = d0; req1_data = d1;
      #1;
      exp0 = (i % 2 == 0);
      n_tests++; if (req0_ready !== exp0 || req1_ready !== !exp0) begin n_fail++; $display("FAIL rr_grant_%0d got r0=%0b r1=%0b exp r0=%0b", i, req0_ready, req1_ready, exp0); end
      n_tests++; if (fifo_data_in !== (exp0 ? d0 : d1)) begin n_fail++; $display("FAIL rr_data_%0d got %h exp %h", i, fifo_data_in, exp0 ? d0 : d1); end
      if (exp0) d0 = d0 + 8'd1; else d1 = d1 + 8'd1;
      @(negedge clk);
    end
    req0_data = d0; req1_data = d1;
    #1;
    n_tests++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || fifo_write !== 1'b0) begin n_fail++; $display("FAIL rr_full_stall got r0=%0b r1=%0b wr=%0b exp 0/0/0", req0_ready, req1_ready, fifo_write); end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    n_tests++; if (both_rdy != 0) begin n_fail++; $display("FAIL rr_both_ready got %0d cycles exp 0", both_rdy); end
  endtask

  task automatic test_gap_order();
    logic [7:0] exp_d [4];
    exp_d[0] = 8'h10; exp_d[1] = 8'h20; exp_d[2] = 8'h11; exp_d[3] = 8'h21;
    wait_until(rr_base + 90);
    n_tests++; if (start_data_q.size() != 4) begin n_fail++; $display("FAIL order_count got %0d exp 4", start_data_q.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < start_data_q.size()) begin
        n_tests++; if (start_data_q[i] !== exp_d[i]) begin n_fail++; $display("FAIL order_byte_%0d got %h exp %h", i, start_data_q[i], exp_d[i]); end
      end
    end
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (i + 1 >= start_cyc_q.size() || i >= fall_cyc_q.size()) begin
        n_fail++; $display("FAIL gap_%0d got missing events exp start 7 cycles after fall", i);
      end else if (start_cyc_q[i+1] - fall_cyc_q[i] != 7) begin
        n_fail++; $display("FAIL gap_%0d got %0d cycles exp 7", i, start_cyc_q[i+1] - fall_cyc_q[i]);
      end
    end
  endtask

  task automatic test_fill();
    int e;
    enable = 1'b0;
    clear_logs();
    for (int i = 0; i < 3; i++) begin
      req0_valid = 1'b1; req0_data = 8'hA0 + 8'(i);
      #1;
      n_tests++; if (req0_ready !== 1'b1 || fifo_write !== 1'b1) begin n_fail++; $display("FAIL fill_accept_%0d got rdy=%0b wr=%0b exp 1/1", i, req0_ready, fifo_write); end
      @(negedge clk);
    end
    req0_data = 8'hA3;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++; if (req0_ready !== 1'b0 || fifo_write !== 1'b0) begin n_fail++; $display("FAIL fill_stall_%0d got rdy=%0b wr=%0b exp 0/0", i, req0_ready, fifo_write); end
      @(negedge clk);
    end
    n_tests++; if (read_cyc_q.size() != 0) begin n_fail++; $display("FAIL fill_no_pop_disabled got %0d pops exp 0", read_cyc_q.size()); end
    enable = 1'b1;
    #1;
    n_tests++; if (fifo_read !== 1'b1 || req0_ready !== 1'b0) begin n_fail++; $display("FAIL fill_enable_pop got rd=%0b rdy=%0b exp 1/0", fifo_read, req0_ready); end
    @(negedge clk);
    #1;
    e = cyc;
    n_tests++; if (req0_ready !== 1'b1 || fifo_data_in !== 8'hA3) begin n_fail++; $display("FAIL fill_fourth_accept got rdy=%0b data=%h exp 1/a3", req0_ready, fifo_data_in); end
    @(negedge clk);
    req0_valid = 1'b0;
    wait_until(e + 90);
    n_tests++; if (start_data_q.size() != 4) begin n_fail++; $display("FAIL fill_drain_count got %0d exp 4", start_data_q.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < start_data_q.size()) begin
        n_tests++; if (start_data_q[i] !== 8'hA0 + 8'(i)) begin n_fail++; $display("FAIL fill_order_%0d got %h exp %h", i, start_data_q[i], 8'hA0 + 8'(i)); end
      end
    end
  endtask

  task automatic test_timeout();
    int t;
    tx_mute = 1'b1;
    clear_logs();
    req0_valid = 1'b1; req0_data = 8'hB1;
    @(negedge clk);
    req0_data = 8'hB2;
    @(negedge clk);
    req0_valid = 1'b0;
    for (int i = 0; i < 10 && start_cyc_q.size() == 0; i++) @(negedge clk);
    n_tests++;
    if (start_cyc_q.size() == 0) begin
      n_fail++; $display("FAIL timeout_first_start got no tx_start exp one within 10 cycles");
      return;
    end
    t = start_cyc_q[0];
    wait_until(t + 63);
    n_tests++; if (tx_err !== 1'b0) begin n_fail++; $display("FAIL timeout_early got tx_err=%0b exp 0 at start+63", tx_err); end
    wait_until(t + 64);
    n_tests++; if (tx_err !== 1'b1) begin n_fail++; $display("FAIL timeout_rise got tx_err=%0b exp 1 at start+64", tx_err); end
    wait_until(t + 70);
    n_tests++; if (start_cyc_q.size() != 2 || start_cyc_q[1] != t + 65 || start_data_q[1] !== 8'hB2) begin n_fail++; $display("FAIL timeout_next_pop got %0d starts exp b2 at cycle %0d", start_cyc_q.size(), t + 65); end
    wait_until(t + 140);
    n_tests++; if (tx_err !== 1'b1 || dut.r_state !== IDLE) begin n_fail++; $display("FAIL timeout_sticky got tx_err=%0b state=%s exp 1/IDLE", tx_err, dut.r_state.name()); end
  endtask

  task automatic test_sync_reset();
    int ns;
    tx_mute = 1'b0;
    req0_valid = 1'b1; req0_data = 8'hC3;
    @(negedge clk);
    req0_valid = 1'b0;
    for (int i = 0; i < 20 && !tx_active; i++) @(negedge clk);
    @(negedge clk);
    n_tests++; if (dut.r_state !== WAIT_DONE) begin n_fail++; $display("FAIL sync_pre_state got %s exp WAIT_DONE", dut.r_state.name()); end
    n_tests++; if (tx_err !== 1'b1) begin n_fail++; $display("FAIL sync_err_held got %0b exp 1", tx_err); end
    ns = start_cyc_q.size();
    sync_reset = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    n_tests++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || fifo_write !== 1'b0) begin n_fail++; $display("FAIL sync_ready got r0=%0b r1=%0b wr=%0b exp 0/0/0", req0_ready, req1_ready, fifo_write); end
    @(negedge clk);
    sync_reset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    n_tests++; if (dut.r_state !== IDLE) begin n_fail++; $display("FAIL sync_state got %s exp IDLE", dut.r_state.name()); end
    n_tests++; if (tx_err !== 1'b0 || tx_data !== 8'h00) begin n_fail++; $display("FAIL sync_clear got err=%0b data=%h exp 0/00", tx_err, tx_data); end
`ifdef UART_TX_SCHED_STATS_EN
    n_tests++; if (tx_count0 !== 16'd0 || tx_count1 !== 16'd0) begin n_fail++; $display("FAIL sync_stats got %0d/%0d exp 0/0", tx_count0, tx_count1); end
`endif
    repeat (20) @(negedge clk);
    n_tests++; if (start_cyc_q.size() != ns) begin n_fail++; $display("FAIL sync_no_reissue got %0d starts exp %0d", start_cyc_q.size(), ns); end
    n_tests++; if (read_empty != 0) begin n_fail++; $display("FAIL read_when_empty got %0d exp 0", read_empty); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got no finish exp finish before 200000 time units");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_gap_order();
    test_fill();
    test_timeout();
    test_sync_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
